mem_stage_mw: RTL
=================

Name: mem_stage_mw

Overview:
- Parametrised pipeline MEM stage for the ARM-style pipelined core. Sits between EX/MEM and writeback.
- Contains the data RAM, byte-lane store/load alignment, and a configurable-latency access FSM that stalls upstream stages. Also holds the MEM/WB pipeline register, with bubble and flush support.
- Successor to the fixed single-cycle, word-only memory stage.

Parameters:
- ADDR_W, 6, word-address bits; RAM depth = 2**ADDR_W 32-bit words.
- LAT, 1, memory access latency in cycles (1..8); LAT=1 means no stall.
- REG_ADDR_W, 4, register-file write address width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCSrcM  in  1  branch/PC-write control from EX/MEM.
- RegWriteM  in  1  register write enable.
- MemtoRegM  in  1  load (writeback selects memory data).
- MemWriteM  in  1  store.
- SizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- SignedM  in  1  sign-extend loads when 1.
- ALUResultM  in  32  byte address / ALU result.
- WriteDataM  in  32  store data (low bits for byte/half).
- WA3M  in  REG_ADDR_W  destination register.
- FlushW  in  1  squash the instruction entering WB.
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  registered controls.
- ReadDataW  out  32  registered, aligned and extended load data.
- ALUOutW  out  32  registered ALUResultM.
- WA3W  out  REG_ADDR_W  registered destination.
- ALUOutM  out  32  combinational copy of ALUResultM (forwarding).
- StallM  out  1  combinational; stall IF/ID/EX and hold EX/MEM.
- MisalignM  out  1  combinational misaligned-access flag.

Behaviour:
- Reset: asynchronous and active-low on rst_n. All W outputs are 0, the FSM is IDLE and the counter is 0. RAM contents are not reset.
- Access definition: access = (MemWriteM | MemtoRegM) & ~MisalignM.
- Misalignment: MisalignM = half & addr[0], or word & (addr[1:0] != 0).
  - A misaligned access does no RAM write and no stall.
  - WB receives RegWriteW=0, MemtoRegW=0; PCSrcW passes through.
- Word index is ALUResultM[ADDR_W+1:2]. Higher address bits are ignored, so addresses wrap modulo the RAM depth.
- Store byte lanes:
  - Byte writes lane addr[1:0] with WriteDataM[7:0].
  - Half writes lanes {addr[1],0} and {addr[1],1} with WriteDataM[15:0].
  - Word writes all four lanes.
  - Untouched lanes keep their value.
- Load extraction: the same lane select, then zero- or sign-extend to 32 bits per SignedM.
- FSM states: IDLE, BUSY.
- LAT=1: every access completes in its own cycle. StallM=0 always and the FSM stays IDLE.
- LAT>1:
  - IDLE with access: StallM=1, counter loads 1, go to BUSY.
  - BUSY with counter < LAT-1: StallM=1, counter increments.
  - BUSY with counter == LAT-1: StallM=0; this is the completion edge. Go to IDLE, counter 0.
  - Total StallM cycles per access = LAT-1. The instruction occupies MEM for LAT cycles.
- Commit: the store writes the RAM only on the completion edge, exactly once.
- Load data: read combinationally from the array and captured into ReadDataW on the completion edge.
- Hazard timing: a store completing at edge N is visible to a load completing at edge N+1 or later.
- MEM/WB register while StallM=1: captures a bubble (PCSrcW, RegWriteW, MemtoRegW = 0; data and WA3W don't-care, hold). This prevents repeated WB effects.
- MEM/WB register otherwise: captures the M-stage values.
- FlushW=1 at a capture edge: loads a bubble, with priority over normal capture.
  - FlushW does not abort a BUSY access. A pending store still commits at completion; only WB effects are suppressed.
- Upstream contract: EX/MEM inputs are held stable while StallM=1. The block does not latch them.
- Reset mid-BUSY: returns to IDLE immediately. A pending store is not committed.
- Back-to-back accesses: IDLE with access on the cycle after completion restarts the stall sequence. There is no idle gap.

Decomposition:
- Shared package mem_pkg holds:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - mstate_t enum (IDLE, BUSY).
  - Constant MAX_LAT = 8.
  - Bubble control constant.
- Sub-module mem_lane_unit: combinational. From addr[1:0], size, signed, write data and RAM word it produces:
  - 4-bit byte-write mask and lane-positioned write data.
  - Extracted/extended load data.
  - Misalign flag.
- The stage instantiates the RAM, mem_lane_unit, the FSM/counter and the MEM/WB register.

Test Plan:
- LAT=1, store word 0xDEADBEEF at 0x10, then load word 0x10, RegWriteM=1, WA3M=3 -> next edge ReadDataW=0xDEADBEEF, WA3W=3, RegWriteW=1, StallM=0 throughout.
- LAT=1, store byte 0x80 at 0x13 over word 0x00000000; load byte signed 0x13 -> 0xFFFFFF80. Load unsigned -> 0x00000080. Load word 0x10 -> 0x80000000.
- LAT=3, load at 0x20 (RAM=0x12345678) -> StallM=1 for 2 cycles, RegWriteW=0 on those edges. Third edge ReadDataW=0x12345678, RegWriteW=1.
- LAT=3, store then load to the same address back-to-back -> two 2-cycle stall windows. The load returns the stored value, and the store writes RAM exactly once (check lanes via snooping).
- Half store at 0x21 -> MisalignM=1, RAM unchanged, StallM=0, RegWriteW=0 next edge.
- LAT=4, store 0xAAAA5555 at 0x30, drop rst_n during the second BUSY cycle -> all W outputs 0 immediately, RAM[0x30] unchanged.
- LAT=4, store 0xAAAA5555 at 0x30, FlushW=1 at completion -> RAM updated, RegWriteW=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage: access size codes,
// access FSM states, the latency ceiling and the MEM/WB control bundle.
package mem_pkg;

    // Load/store size encoding; 2'b11 is reserved and handled as a word.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    // Access FSM: IDLE accepts a new access, BUSY counts out the latency.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mstate_t;

    // Largest supported access latency and the counter width it needs.
    localparam int MAX_LAT = 8;
    localparam int CNT_W   = $clog2(MAX_LAT);

    // Control bits carried through the MEM/WB register.
    typedef struct packed {
        logic pcSrc;
        logic regWrite;
        logic memtoReg;
    } wbCtrl_t;

    // A bubble has no architectural effect in writeback.
    localparam wbCtrl_t WB_BUBBLE = '{pcSrc: 1'b0, regWrite: 1'b0, memtoReg: 1'b0};

    // Zero- or sign-extend a byte (raw[7:0]) or half (raw[15:0]) to 32 bits.
    function automatic logic [31:0] extendLoad(input logic [15:0] raw,
                                               input logic        isHalf,
                                               input logic        sgn);
        logic [31:0] res;
        if (isHalf) begin
            res = sgn ? {{16{raw[15]}}, raw} : {16'b0, raw};
        end else begin
            res = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'b0, raw[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for the data RAM: builds the store write mask and
// lane-replicated store data, extracts and extends load data from the
// addressed RAM word, and flags accesses that break natural alignment.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Decode size and low address bits into lane mask, store data and load data.
    always_comb begin
        wmask_o    = 4'b0000;
        wlane_o    = wdata_i;
        rdata_o    = rword_i;
        misalign_o = 1'b0;
        byteSel    = 8'h00;
        halfSel    = 16'h0000;
        case (size_i)
            SZ_BYTE: begin
                wlane_o = {4{wdata_i[7:0]}};
                case (addr_i)
                    2'd0: begin
                        wmask_o = 4'b0001;
                        byteSel = rword_i[7:0];
                    end
                    2'd1: begin
                        wmask_o = 4'b0010;
                        byteSel = rword_i[15:8];
                    end
                    2'd2: begin
                        wmask_o = 4'b0100;
                        byteSel = rword_i[23:16];
                    end
                    default: begin
                        wmask_o = 4'b1000;
                        byteSel = rword_i[31:24];
                    end
                endcase
                rdata_o = extendLoad({8'h00, byteSel}, 1'b0, signed_i);
            end
            SZ_HALF: begin
                misalign_o = addr_i[0];
                wlane_o    = {2{wdata_i[15:0]}};
                if (addr_i[1]) begin
                    wmask_o = 4'b1100;
                    halfSel = rword_i[31:16];
                end else begin
                    wmask_o = 4'b0011;
                    halfSel = rword_i[15:0];
                end
                rdata_o = extendLoad(halfSel, 1'b1, signed_i);
            end
            default: begin
                misalign_o = |addr_i;
                wmask_o    = 4'b1111;
                wlane_o    = wdata_i;
                rdata_o    = rword_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_mw.sv
// MEM stage of the pipelined core: data RAM with byte-lane access, a
// latency-counting access FSM that stalls the front of the pipe, and the
// MEM/WB pipeline register with bubble insertion and writeback flush.
module mem_stage_mw
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int LAT        = 1,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCSrcM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic                  MemWriteM,
    input  logic [1:0]            SizeM,
    input  logic                  SignedM,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    input  logic [REG_ADDR_W-1:0] WA3M,
    input  logic                  FlushW,
    output logic                  PCSrcW,
    output logic                  RegWriteW,
    output logic                  MemtoRegW,
    output logic [31:0]           ReadDataW,
    output logic [31:0]           ALUOutW,
    output logic [REG_ADDR_W-1:0] WA3W,
    output logic [31:0]           ALUOutM,
    output logic                  StallM,
    output logic                  MisalignM
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LAT - 1);

    // Data RAM; contents survive reset.
    logic [31:0] ram_q [DEPTH];

    logic [ADDR_W-1:0] wordIdx;
    logic [31:0]       ramWord;
    logic [3:0]        wmask;
    logic [31:0]       wlane;
    logic [31:0]       loadData;
    logic              misalign;
    logic              isMemOp;
    logic              access;
    logic              stall;
    logic              complete;
    logic              commit;

    mstate_t           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    wbCtrl_t               wbCtrl_q, wbCtrl_d;
    logic [31:0]           readData_q, readData_d;
    logic [31:0]           aluOut_q, aluOut_d;
    logic [REG_ADDR_W-1:0] wa3_q, wa3_d;

    // Upper address bits beyond the RAM depth are dropped, so addresses wrap.
    assign wordIdx = ALUResultM[ADDR_W+1:2];
    assign ramWord = ram_q[wordIdx];

    mem_lane_unit u_lane (
        .addr_i     (ALUResultM[1:0]),
        .size_i     (SizeM),
        .signed_i   (SignedM),
        .wdata_i    (WriteDataM),
        .rword_i    (ramWord),
        .wmask_o    (wmask),
        .wlane_o    (wlane),
        .rdata_o    (loadData),
        .misalign_o (misalign)
    );

    // A misaligned load/store is dropped entirely: no RAM activity, no stall.
    assign isMemOp = MemWriteM | MemtoRegM;
    assign access  = isMemOp & ~misalign;
    assign commit  = complete & MemWriteM & ~misalign;

    assign ALUOutM   = ALUResultM;
    assign StallM    = stall;
    assign MisalignM = misalign;

    // Access FSM next state: count LAT-1 stall cycles, completing on the last.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        complete = 1'b0;
        if (LAT == 1) begin
            complete = access;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        stall   = 1'b1;
                        cnt_d   = CNT_W'(1);
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q < LAST_CNT) begin
                        stall = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Access FSM state and latency counter; reset abandons any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store commit: only the enabled byte lanes change, once, at completion.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wmask[lane]) begin
                    ram_q[wordIdx][8*lane +: 8] <= wlane[8*lane +: 8];
                end
            end
        end
    end

    // MEM/WB next value: flush or stall inserts a bubble and holds the data.
    always_comb begin
        wbCtrl_d   = wbCtrl_q;
        readData_d = readData_q;
        aluOut_d   = aluOut_q;
        wa3_d      = wa3_q;
        if (FlushW || stall) begin
            wbCtrl_d = WB_BUBBLE;
        end else begin
            wbCtrl_d.pcSrc    = PCSrcM;
            wbCtrl_d.regWrite = RegWriteM & ~(isMemOp & misalign);
            wbCtrl_d.memtoReg = MemtoRegM & ~misalign;
            readData_d        = loadData;
            aluOut_d          = ALUResultM;
            wa3_d             = WA3M;
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbCtrl_q   <= WB_BUBBLE;
            readData_q <= '0;
            aluOut_q   <= '0;
            wa3_q      <= '0;
        end else begin
            wbCtrl_q   <= wbCtrl_d;
            readData_q <= readData_d;
            aluOut_q   <= aluOut_d;
            wa3_q      <= wa3_d;
        end
    end

    assign PCSrcW    = wbCtrl_q.pcSrc;
    assign RegWriteW = wbCtrl_q.regWrite;
    assign MemtoRegW = wbCtrl_q.memtoReg;
    assign ReadDataW = readData_q;
    assign ALUOutW   = aluOut_q;
    assign WA3W      = wa3_q;

endmodule
